pif_prefetch: RTL and testbench
===============================

Name: pif_prefetch

Overview:
- Parametrised instruction-fetch stage with a FIFO prefetch buffer between the icache and the IF/ID register.
- Keeps one icache request in flight whenever buffer space exists, so ID consumes buffered instructions during icache latency.
- Jumps flush the buffer and discard any in-flight response.
- Sits between the icache port and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width
FIFO_DEPTH, 4, buffer entries; power of two, >=2
RESET_PC, 0, fetch PC after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
jump_en  in  1  redirect request from EX
jump_addr  in  ADDR_W  redirect target
stall  in  1  downstream full stall; head entry is not consumed
icache_read_flag  out  1  one-cycle request pulse
icache_addr  out  ADDR_W  request address; valid with read_flag
icache_read_data  in  DATA_W  returned instruction; valid with done
icache_busy  in  1  icache cannot accept a request
icache_done  in  1  one-cycle response strobe
inst  out  DATA_W  head instruction; 0 (bubble) when empty
pc_addr  out  ADDR_W  head PC; 0 when empty
inst_valid  out  1  buffer not empty

Behaviour:
- Reset (asynchronous, rst=1):
  - State IDLE, FIFO empty, fetch_pc=RESET_PC.
  - All outputs 0.
  - The icache shares rst; any response arriving after reset is ignored because the block is in IDLE.
- FSM states IDLE, WAIT, DRAIN.
- IDLE:
  - Issue condition: !jump_en && !icache_busy && count<FIFO_DEPTH.
  - On issue: icache_read_flag=1 and icache_addr=fetch_pc, combinationally in that cycle only; next state WAIT.
  - Otherwise read_flag=0.
- WAIT:
  - On icache_done: write {fetch_pc, read_data} to FIFO, fetch_pc+=4 (wraps modulo 2^ADDR_W), go to IDLE.
  - Minimum issue-to-issue spacing is 2 cycles, so at most one request is outstanding.
- Redirect (jump_en=1, any state):
  - Clear the FIFO in the same cycle; a simultaneous pop is void.
  - fetch_pc<=jump_addr.
  - In WAIT without done: go to DRAIN.
  - In WAIT with done in the same cycle: drop the data and go to IDLE.
  - In IDLE: stay in IDLE; no request is issued that cycle.
- DRAIN:
  - read_flag=0. On icache_done, discard the data and go to IDLE.
  - A further jump_en in DRAIN updates fetch_pc and stays in DRAIN.
- Pop rule: pop the head when inst_valid && !stall && !jump_en.
- Simultaneous push and pop:
  - Allowed when full: count is unchanged and the pushed entry goes in behind.
  - Allowed when empty: the pushed entry becomes visible next cycle. There is no bypass, so fill-to-output latency is 1 cycle after done.
- Issue decision: uses the registered count only (no credit for a same-cycle pop), so overflow is impossible. Full buffer means no new request.
- Outputs: inst/pc_addr are driven combinationally from the FIFO head; inst_valid=(count!=0).
- Pointers: ($clog2(FIFO_DEPTH)+1)-bit read/write pointers with wrap; full when MSBs differ and the low bits are equal.

Optional Feature:
- Macro PIF_PREFETCH_STATS_EN.
- Defined: adds outputs stat_fetch_cnt[31:0] and stat_flush_cnt[31:0].
  - stat_fetch_cnt increments on every FIFO push.
  - stat_flush_cnt increments per jump_en cycle that discards at least one valid entry or an in-flight response.
  - Both are saturating, cleared by rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t {pc, inst}.
  - enum fetch_state_t {IDLE, WAIT, DRAIN}.
  - constant INST_BYTES=4.
- Sub-module fetch_fifo:
  - Parametrised by depth and entry type.
  - Ports: push, pop, flush, full, empty, count, head.

Test Plan:
- Reset with RESET_PC=0x100, busy=0, done asserted 2 cycles after each read_flag, stall=1 -> requests at 0x100,0x104,0x108,0x10C; then read_flag stays 0 with count=4, inst_valid=1, pc_addr=0x100.
- Continue from the previous scenario and release stall -> pops in order at 0x100..0x10C, one per cycle; refills resume; no entry lost or duplicated.
- jump_en to 0x200 while in WAIT, done arriving 3 cycles later with 0xDEADBEEF -> FIFO empty (inst=0, inst_valid=0); 0xDEADBEEF never appears; next icache_addr=0x200.
- jump_en in the same cycle as done -> data dropped, IDLE next cycle, next request at jump_addr.
- icache_busy held high 5 cycles in IDLE -> read_flag stays 0; first request one cycle after busy falls, same address.
- Async rst pulse mid-WAIT -> outputs 0 immediately, not at the clock edge; the done arriving after reset is ignored; first request after reset at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch stage: FIFO entry, FSM state
// encoding and the fixed instruction size used to advance the fetch PC.
package fetch_pkg;

  localparam int INST_BYTES = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO with wrap-bit pointers. Flush empties the
// buffer in one cycle and overrides any push/pop in that cycle. A push while
// full is accepted only together with a pop (the new entry lands behind).
module fetch_fifo import fetch_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        push_data,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] count,
  output entry_t        head
);

  localparam int IW = PW - 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Status flags and head view derived from the registered pointers
  always_comb begin
    full    = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[IW-1:0] == rptr_q[IW-1:0]);
    empty   = (wptr_q == rptr_q);
    count   = wptr_q - rptr_q;
    head    = mem_q[rptr_q[IW-1:0]];
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
  end

  // Next pointer / storage values
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q[IW-1:0]] = push_data;
        wptr_d                = wptr_q + PW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PW'(1);
      end
    end
  end

  // Pointer and storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/pif_prefetch.sv
// Instruction fetch stage with prefetch buffer. Keeps at most one icache
// request outstanding whenever the buffer has room; a redirect flushes the
// buffer and any in-flight response is discarded via the DRAIN state.
// Optional build macro PIF_PREFETCH_STATS_EN adds saturating fetch/flush
// counters as extra outputs.
//
// state | meaning
// IDLE  | no request outstanding; issue when buffer has room and icache free
// WAIT  | request outstanding; response will be written to the buffer
// DRAIN | request outstanding after a redirect; response will be dropped
module pif_prefetch import fetch_pkg::*; #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              stall,
  output logic              icache_read_flag,
  output logic [ADDR_W-1:0] icache_addr,
  input  logic [DATA_W-1:0] icache_read_data,
  input  logic              icache_busy,
  input  logic              icache_done,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              inst_valid
`ifdef PIF_PREFETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetch_cnt,
  output logic [31:0]       stat_flush_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PW-1:0]     fifo_count;
  entry_t            head;
  entry_t            push_entry;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (jump_en),
    .push_data (push_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

  // State register and fetch PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next-state logic; a redirect with a response still pending goes to DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = WAIT;
      WAIT:    begin
        if (icache_done)  state_d = IDLE;
        else if (jump_en) state_d = DRAIN;
      end
      DRAIN:   if (icache_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: request strobe, buffer push/pop and head view
  always_comb begin
    // Issue looks at the registered count only, so a same-cycle pop earns no credit
    issue            = (state_q == IDLE) && !jump_en && !icache_busy &&
                       (fifo_count < PW'(FIFO_DEPTH)) && !rst;
    icache_read_flag = issue;
    icache_addr      = issue ? fetch_pc_q : '0;
    push             = (state_q == WAIT) && icache_done && !jump_en && (!fifo_full || pop);
    push_entry       = '{pc: fetch_pc_q, inst: icache_read_data};
    pop              = !fifo_empty && !stall && !jump_en;
    inst_valid       = !fifo_empty;
    inst             = fifo_empty ? '0 : head.inst;
    pc_addr          = fifo_empty ? '0 : head.pc;
  end

  // Fetch PC: redirect wins, otherwise advance on each accepted response
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (jump_en)   fetch_pc_d = jump_addr;
    else if (push) fetch_pc_d = fetch_pc_q + ADDR_W'(INST_BYTES);
  end

`ifdef PIF_PREFETCH_STATS_EN
  logic [31:0] stat_fetch_q, stat_fetch_d;
  logic [31:0] stat_flush_q, stat_flush_d;
  logic        flush_evt;

  // Saturating counters for pushes and redirects that threw work away
  always_comb begin
    flush_evt    = jump_en && (!fifo_empty || (state_q != IDLE));
    stat_fetch_d = stat_fetch_q;
    stat_flush_d = stat_flush_q;
    if (push && (stat_fetch_q != '1))      stat_fetch_d = stat_fetch_q + 32'd1;
    if (flush_evt && (stat_flush_q != '1)) stat_flush_d = stat_flush_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetch_q <= '0;
      stat_flush_q <= '0;
    end else begin
      stat_fetch_q <= stat_fetch_d;
      stat_flush_q <= stat_flush_d;
    end
  end

  assign stat_fetch_cnt = stat_fetch_q;
  assign stat_flush_cnt = stat_flush_q;
`endif

endmodule

// File: tb/tb_pif_prefetch.sv
// Bench for pif_prefetch: icache responder plus a queue-based model of the
// prefetch buffer (one outstanding request, redirect discards everything).
module tb_pif_prefetch;

  localparam int          D   = 4;
  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        stall;
  logic        icache_read_flag;
  logic [31:0] icache_addr;
  logic [31:0] icache_read_data;
  logic        icache_busy;
  logic        icache_done;
  logic [31:0] inst;
  logic [31:0] pc_addr;
  logic        inst_valid;

  always #5 clk = ~clk;

  pif_prefetch #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (D),
    .RESET_PC   (RPC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .jump_en          (jump_en),
    .jump_addr        (jump_addr),
    .stall            (stall),
    .icache_read_flag (icache_read_flag),
    .icache_addr      (icache_addr),
    .icache_read_data (icache_read_data),
    .icache_busy      (icache_busy),
    .icache_done      (icache_done),
    .inst             (inst),
    .pc_addr          (pc_addr),
    .inst_valid       (inst_valid)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_disc;

  bit          ic_pend;
  int          ic_cnt;
  logic [31:0] ic_data;
  int          lat;

  function automatic logic [31:0] dfn(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_2468;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc   = RPC;
    m_out  = 1'b0;
    m_disc = 1'b0;
  endtask

  // One clock: drive icache, form expectation, sample, advance model and icache.
  // Entered and left 1 time unit after a rising edge.
  task automatic step(output logic [97:0] obs, output logic [97:0] exp);
    bit ef;
    bit pop;
    int n;
    icache_done      = ic_pend && (ic_cnt == 0);
    icache_read_data = icache_done ? ic_data : $urandom;
    n  = mq.size();
    ef = !m_out && !jump_en && !icache_busy && (n < D);
    exp = {ef, ef ? m_pc : 32'h0, n != 0, n != 0 ? mq[0].ins : 32'h0, n != 0 ? mq[0].pc : 32'h0};
    #4;
    obs = {icache_read_flag, icache_read_flag ? icache_addr : 32'h0, inst_valid, inst, pc_addr};
    pop = (n != 0) && !stall && !jump_en;
    if (jump_en) begin
      mq.delete();
      if (m_out && !icache_done) m_disc = 1'b1;
      else begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end
      m_pc = jump_addr;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_out && icache_done) begin
        if (!m_disc) begin
          mq.push_back(ent_t'{m_pc, icache_read_data});
          m_pc = m_pc + 32'd4;
        end
        m_out  = 1'b0;
        m_disc = 1'b0;
      end
      if (ef) m_out = 1'b1;
    end
    if (icache_done) ic_pend = 1'b0;
    if (icache_read_flag) begin
      ic_pend = 1'b1;
      ic_cnt  = lat;
      ic_data = dfn(icache_addr);
    end
    @(posedge clk);
    #1;
    if (ic_pend) ic_cnt--;
  endtask

  task automatic test_reset();
    logic [97:0] o;
    rst = 1'b1; jump_en = 1'b0; jump_addr = '0; stall = 1'b0;
    icache_busy = 1'b0; icache_done = 1'b0; icache_read_data = '0;
    ic_pend = 1'b0; ic_cnt = 0; ic_data = '0; lat = 2;
    #1;
    o = {icache_read_flag, icache_addr, inst_valid, inst, pc_addr};
    checks++;
    if (o !== 98'h0) begin
      errors++;
      $display("FAIL reset_initial outputs=%h want 0", o);
    end
    repeat (2) @(posedge clk);
    #1;
    o = {icache_read_flag, icache_addr, inst_valid, inst, pc_addr};
    checks++;
    if (o !== 98'h0) begin
      errors++;
      $display("FAIL reset_held outputs=%h want 0", o);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    logic [97:0] o, e;
    logic [31:0] issued[$];
    int          guard = 0;
    stall = 1'b1;
    lat   = 2;
    while (!(mq.size() == D && !m_out) && guard < 40) begin
      step(o, e);
      if (o[97]) issued.push_back(o[96:65]);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fill got=%h want=%h", o, e);
      end
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL fill_timeout size=%0d want %0d", mq.size(), D);
    end
    checks++;
    if (issued.size() != D) begin
      errors++;
      $display("FAIL fill_req_count got=%0d want=%0d", issued.size(), D);
    end else begin
      for (int i = 0; i < D; i++) begin
        checks++;
        if (issued[i] !== RPC + 32'(4 * i)) begin
          errors++;
          $display("FAIL fill_req_addr[%0d] got=%h want=%h", i, issued[i], RPC + 32'(4 * i));
        end
      end
    end
    repeat (3) begin
      step(o, e);
      checks++;
      if (o !== {1'b0, 32'h0, 1'b1, dfn(RPC), RPC}) begin
        errors++;
        $display("FAIL fill_full_hold got=%h want=%h", o, {1'b0, 32'h0, 1'b1, dfn(RPC), RPC});
      end
    end
  endtask

  task automatic test_drain();
    logic [97:0] o, e;
    logic [31:0] popped[$];
    stall = 1'b0;
    repeat (20) begin
      step(o, e);
      if (o[64]) popped.push_back(o[31:0]);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL drain got=%h want=%h", o, e);
      end
    end
    for (int i = 0; i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== RPC + 32'(4 * i)) begin
        errors++;
        $display("FAIL drain_order[%0d] got=%h want=%h", i, popped[i], RPC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_jump_wait();
    logic [97:0] o, e;
    int          guard = 0;
    bit          seen_req = 1'b0;
    stall = 1'b0;
    lat   = 4;
    while (!(m_out && !m_disc && ic_pend && ic_cnt >= 1) && guard < 30) begin
      step(o, e);
      guard++;
    end
    checks++;
    if (guard >= 30) begin
      errors++;
      $display("FAIL jump_wait_setup no outstanding request");
    end
    ic_cnt    = 3;
    ic_data   = 32'hDEADBEEF;
    jump_en   = 1'b1;
    jump_addr = 32'h200;
    step(o, e);
    jump_en = 1'b0;
    lat     = 2;
    for (int i = 0; i < 12; i++) begin
      step(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL jump_wait got=%h want=%h", o, e);
      end
      if (i < 3) begin
        checks++;
        if (o[64] !== 1'b0 || o[63:32] !== 32'h0) begin
          errors++;
          $display("FAIL jump_wait_flushed valid=%b inst=%h want 0/0", o[64], o[63:32]);
        end
      end
      if (o[63:32] === 32'hDEADBEEF) begin
        checks++;
        errors++;
        $display("FAIL jump_wait_stale inst=%h want never DEADBEEF", o[63:32]);
      end
      if (o[97] && !seen_req) begin
        seen_req = 1'b1;
        checks++;
        if (o[96:65] !== 32'h200) begin
          errors++;
          $display("FAIL jump_wait_target got=%h want=%h", o[96:65], 32'h200);
        end
      end
    end
    checks++;
    if (!seen_req) begin
      errors++;
      $display("FAIL jump_wait_no_request got=0 want=1");
    end
  endtask

  task automatic test_jump_done();
    logic [97:0] o, e;
    logic [31:0] ja;
    int          guard = 0;
    stall = 1'b1;
    lat   = 2;
    while (!(m_out && !m_disc && ic_pend && ic_cnt == 0) && guard < 30) begin
      step(o, e);
      guard++;
    end
    checks++;
    if (guard >= 30) begin
      errors++;
      $display("FAIL jump_done_setup no response pending");
    end
    ja        = $urandom & 32'h0000_FFFC;
    jump_en   = 1'b1;
    jump_addr = ja;
    step(o, e);
    jump_en = 1'b0;
    step(o, e);
    checks++;
    if (o !== {1'b1, ja, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL jump_done_next got=%h want=%h", o, {1'b1, ja, 1'b0, 32'h0, 32'h0});
    end
    repeat (6) begin
      step(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL jump_done got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_busy();
    logic [97:0] o, e;
    int          guard = 0;
    stall       = 1'b0;
    icache_busy = 1'b1;
    while (m_out && guard < 20) begin
      step(o, e);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("FAIL busy_setup still outstanding");
    end
    repeat (5) begin
      step(o, e);
      checks++;
      if (o[97] !== 1'b0 || o !== e) begin
        errors++;
        $display("FAIL busy_hold got=%h want=%h", o, e);
      end
    end
    icache_busy = 1'b0;
    e = '0;
    e[97] = 1'b1;
    e[96:65] = m_pc;
    step(o, e);
    checks++;
    if (o[97:65] !== e[97:65]) begin
      errors++;
      $display("FAIL busy_release got=%h want=%h", o[97:65], e[97:65]);
    end
    repeat (4) step(o, e);
  endtask

  task automatic test_async_rst();
    logic [97:0] o, e;
    int          guard = 0;
    stall = 1'b1;
    lat   = 3;
    while (!(mq.size() > 0 && m_out && ic_pend && ic_cnt >= 1) && guard < 40) begin
      step(o, e);
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL rst_setup no outstanding request with data buffered");
    end
    icache_done = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    o = {icache_read_flag, icache_addr, inst_valid, inst, pc_addr};
    checks++;
    if (o !== 98'h0) begin
      errors++;
      $display("FAIL rst_async outputs=%h want 0", o);
    end
    model_reset();
    @(posedge clk);
    #1;
    if (ic_pend) ic_cnt--;
    rst         = 1'b0;
    stall       = 1'b0;
    icache_busy = 1'b1;
    guard = 0;
    while (ic_pend && guard < 10) begin
      step(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_stale got=%h want=%h", o, e);
      end
      guard++;
    end
    icache_busy = 1'b0;
    step(o, e);
    checks++;
    if (o !== {1'b1, RPC, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL rst_first_req got=%h want=%h", o, {1'b1, RPC, 1'b0, 32'h0, 32'h0});
    end
    repeat (6) begin
      step(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_after got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_random();
    logic [97:0] o, e;
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 2) == 0);
      icache_busy = ($urandom_range(0, 4) == 0);
      lat         = $urandom_range(1, 4);
      jump_en     = ($urandom_range(0, 22) == 0);
      jump_addr   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      step(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random[%0d] got=%h want=%h", i, o, e);
      end
    end
    jump_en     = 1'b0;
    icache_busy = 1'b0;
    stall       = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_jump_wait();
    test_jump_done();
    test_busy();
    test_async_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
